// File: rtl/key_event_ctrl.sv
//------------------------------------------------------------------------------
// Module  : key_event_ctrl
// Brief   : Avalon-MM pushbutton controller: sync, debounce, press-edge IRQ.
//           Optional per-key event FIFO when KEY_EVENT_CTRL_FIFO_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module key_event_ctrl #(
  parameter int WIDTH    = 4,
  parameter int DB_BITS  = 16,
  parameter int DB_RESET = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0]   r_sync1;
  logic [WIDTH-1:0]   r_sync2;
  logic [WIDTH-1:0]   r_stable;
  logic [WIDTH-1:0]   r_stable_d;
  logic [WIDTH-1:0]   r_mask;
  logic [WIDTH-1:0]   r_edge;
  logic [DB_BITS-1:0] r_cnt [WIDTH];
  logic [DB_BITS-1:0] r_reload;
  logic               r_irq;
  logic [31:0]        r_readdata;

  logic               w_wr;
  logic [WIDTH-1:0]   w_press;
  logic [WIDTH-1:0]   w_edge_clr;
  logic [WIDTH-1:0]   w_data;
  logic [31:0]        w_event_word;
  logic [31:0]        w_rd;
  logic               w_unused;

  assign w_wr       = chipselect & ~write_n;
  assign w_press    = r_stable_d & ~r_stable;
  assign w_edge_clr = (w_wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
  assign w_data     = ~r_stable;
  assign w_unused   = ^{read, writedata};

  assign readdata = r_readdata;
  assign irq      = r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  // The counter compares against the live reload, so a smaller reload
  // written mid-count lets the counter run on and wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable   <= '1;
      r_stable_d <= '1;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_stable_d <= r_stable;
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == r_reload) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask   <= '0;
      r_reload <= DB_BITS'(DB_RESET);
      r_edge   <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && address == 3'd1) r_mask <= writedata[WIDTH-1:0];
      if (w_wr && address == 3'd2) r_reload <= writedata[DB_BITS-1:0];
      r_edge <= (r_edge & ~w_edge_clr) | w_press;
      r_irq  <= |(r_edge & r_mask);
    end
  end

`ifdef KEY_EVENT_CTRL_FIFO_EN
  localparam int c_DEPTH = 8;

  logic [WIDTH-1:0] r_pend;
  logic [8:0]       r_fifo [c_DEPTH];
  logic [2:0]       r_wr_ptr;
  logic [2:0]       r_rd_ptr;
  logic [3:0]       r_count;
  logic             r_ovf;

  logic [WIDTH-1:0] w_pick;
  logic [2:0]       w_sel;
  logic [8:0]       w_entry;
  logic             w_push;
  logic             w_ev_rd;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_store;

  // Lowest-index pending key wins; direction comes from stable right now.
  assign w_pick = r_pend & (-r_pend);

  always_comb begin
    w_sel = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r_pend[i]) w_sel = 3'(i);
    end
  end

  assign w_entry = {|(w_pick & ~r_stable), 8'(w_sel)};
  assign w_push  = |r_pend;
  assign w_ev_rd = chipselect & read & (address == 3'd4);
  assign w_empty = (r_count == 4'd0);
  assign w_full  = (r_count == 4'(c_DEPTH));
  assign w_pop   = w_ev_rd & ~w_empty;
  assign w_store = w_push & (~w_full | w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_pend <= (r_pend | (r_stable ^ r_stable_d)) & ~w_pick;
      if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_ev_rd)               r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) r_fifo[r_wr_ptr] <= w_entry;
  end

  assign w_event_word = {~w_empty, r_ovf, 21'b0, (w_empty ? 9'b0 : r_fifo[r_rd_ptr])};
`else
  assign w_event_word = '0;
`endif

  always_comb begin
    w_rd = '0;
    case (address)
      3'd0:    w_rd = 32'(w_data);
      3'd1:    w_rd = 32'(r_mask);
      3'd2:    w_rd = 32'(r_reload);
      3'd3:    w_rd = 32'(r_edge);
      3'd4:    w_rd = w_event_word;
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rd;
  end

endmodule

`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_key_event_ctrl
// Brief   : Self-checking bench for key_event_ctrl with a behavioural model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_key_event_ctrl;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        read;
  logic        write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_pass  = 0;
  int n_total = 0;

  key_event_ctrl #(.WIDTH(W), .DB_BITS(16), .DB_RESET(50000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
  endfunction

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_hist[$];          // [0] = synchronized value, [1] = first stage
  logic [W-1:0] m_stable, m_stable_prev, m_mask, m_edge, m_pend;
  int           m_run [W];          // consecutive cycles the synced level disagreed
  logic [15:0]  m_reload;
  logic         m_irq, m_ovf;
  logic [31:0]  m_rd;
  logic [8:0]   m_q[$];

  task automatic m_reset();
    m_hist = '{4'hF, 4'hF};
    m_stable = '1; m_stable_prev = '1; m_mask = '0; m_edge = '0; m_pend = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
    m_reload = 16'd50000; m_irq = 0; m_ovf = 0; m_rd = '0;
    m_q.delete();
  endtask

  task automatic m_step();
    logic [W-1:0] s_old, pick, clr, st_new, inv;
    logic [31:0]  rd;
    logic         wr, evrd, pop;
    int           k;
    s_old = m_hist[0];
    wr    = chipselect && !write_n;
    evrd  = chipselect && read && (address == 3'd4);
    inv   = ~m_stable;
    case (address)
      3'd0: rd = {28'b0, inv};
      3'd1: rd = {28'b0, m_mask};
      3'd2: rd = {16'b0, m_reload};
      3'd3: rd = {28'b0, m_edge};
`ifdef KEY_EVENT_CTRL_FIFO_EN
      3'd4: rd = (m_q.size() > 0) ? {1'b1, m_ovf, 21'b0, m_q[0]} : {1'b0, m_ovf, 30'b0};
`endif
      default: rd = '0;
    endcase
`ifdef KEY_EVENT_CTRL_FIFO_EN
    pick = '0;
    k = -1;
    for (int i = W - 1; i >= 0; i--) if (m_pend[i]) k = i;
    pop = evrd && (m_q.size() > 0);
    if (pop) void'(m_q.pop_front());
    if (evrd) m_ovf = 1'b0;
    if (k >= 0) begin
      pick[k] = 1'b1;
      if (m_q.size() < 8) m_q.push_back({~m_stable[k], 8'(k)});
      else m_ovf = 1'b1;
    end
    m_pend = (m_pend | (m_stable ^ m_stable_prev)) & ~pick;
`else
    pop = 1'b0;
    pick = '0;
    k = pop ? 0 : -1;
`endif
    clr    = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
    m_irq  = |(m_edge & m_mask);
    m_edge = (m_edge & ~clr) | (m_stable_prev & ~m_stable);
    if (wr && address == 3'd1) m_mask = writedata[W-1:0];
    st_new = m_stable;
    for (int i = 0; i < W; i++) begin
      if (s_old[i] == m_stable[i]) m_run[i] = 0;
      else if ((m_run[i] % 65536) == int'(m_reload)) begin
        st_new[i] = s_old[i];
        m_run[i]  = 0;
      end else m_run[i]++;
    end
    m_stable_prev = m_stable;
    m_stable      = st_new;
    if (wr && address == 3'd2) m_reload = writedata[15:0];
    void'(m_hist.pop_front());
    m_hist.push_back(in_port);
    m_rd = rd;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_reset();
    else          m_step();
  end

  // Every-cycle comparison against the model, well away from the active edge.
  always begin
    @(posedge clk);
    #4;
    if (reset_n === 1'b1) begin
      check("rd_model", readdata, m_rd);
      check("irq_model", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(logic [2:0] a, logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic drain();
    logic [31:0] d;
    for (int i = 0; i < 12; i++) begin
      bus_read(3'd4, d);
      if (!d[31]) break;
    end
  endtask

  initial begin
    logic [31:0] d;
    int hold;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; read = 1'b0;
    write_n = 1'b1; writedata = '0; in_port = '1;
    tick(3);
    reset_n = 1'b1;
    tick(1);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    bus_read(3'd0, d); check("reset_data", d, 32'h0);
    bus_read(3'd2, d); check("reset_debounce", d, 32'd50000);

    // Glitches shorter than reload+1 are filtered.
    bus_write(3'd2, 32'd3);
    for (int g = 0; g < 3; g++) begin
      in_port[0] = 1'b0; tick(2);
      in_port[0] = 1'b1; tick(3);
    end
    tick(6);
    bus_read(3'd0, d); check("glitch_data", d, 32'h0);

    // Stable falls on edge 6 after the pin; readdata shows it one edge later.
    address = 3'd0;
    in_port[0] = 1'b0;
    tick(6); check("data_before", readdata, 32'h0);
    tick(1); check("data_after", readdata, 32'h1);

    bus_write(3'd1, 32'h1);
    tick(2); check("irq_masked_on", {31'b0, irq}, 32'h1);
    bus_read(3'd3, d); check("edge_set", d, 32'h1);
    bus_write(3'd3, 32'h1);
    check("irq_lag", {31'b0, irq}, 32'h1);
    tick(1); check("irq_cleared", {31'b0, irq}, 32'h0);

    in_port[0] = 1'b1; tick(10);
    bus_read(3'd3, d); check("release_no_edge", d, 32'h0);
    in_port[0] = 1'b0;
    tick(6);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, d); check("edge_set_wins", d, 32'h1);

    in_port[0] = 1'b1; tick(10);
    bus_write(3'd3, 32'h1);
    bus_write(3'd1, 32'h2);
    in_port[0] = 1'b0; tick(10);
    bus_read(3'd3, d); check("edge_unmasked", d, 32'h1);
    check("irq_unmasked", {31'b0, irq}, 32'h0);
    in_port[0] = 1'b1; tick(10);

`ifdef KEY_EVENT_CTRL_FIFO_EN
    drain();
    in_port = 4'b1010; tick(10);
    bus_read(3'd4, d); check("fifo_pop_k0", d, 32'h8000_0100);
    bus_read(3'd4, d); check("fifo_pop_k2", d, 32'h8000_0102);
    bus_read(3'd4, d); check("fifo_empty", d, 32'h0000_0000);
    in_port = 4'hF; tick(10);
    drain();
    in_port = 4'h0; tick(10);
    in_port = 4'hF; tick(10);
    in_port = 4'hE; tick(10);
    bus_read(3'd4, d); check("fifo_ovf_first", d, 32'hC000_0100);
    bus_read(3'd4, d); check("fifo_ovf_cleared", d, 32'h8000_0101);
    for (int i = 0; i < 6; i++) begin
      bus_read(3'd4, d); check("fifo_valid", {31'b0, d[31]}, 32'h1);
    end
    bus_read(3'd4, d); check("fifo_dropped", d, 32'h0);
    in_port = 4'hF; tick(10);
    drain();
`else
    bus_read(3'd4, d); check("event_absent", d, 32'h0);
`endif

    // Randomized traffic; the every-cycle compare does the checking.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      int op;
      logic [2:0] a;
      if (hold == 0) begin
        in_port = W'($urandom);
        hold = $urandom_range(1, 10);
      end
      hold--;
      op = $urandom_range(0, 9);
      a  = 3'($urandom_range(0, 7));
      address = a; chipselect = 1'b0; read = 1'b0; write_n = 1'b1;
      writedata = (a == 3'd2) ? 32'($urandom_range(0, 6)) : $urandom;
      if (op <= 1) begin chipselect = 1'b1; write_n = 1'b0; end
      else if (op <= 4) begin chipselect = 1'b1; read = 1'b1; end
      else if (op == 5) write_n = 1'b0;
      else if (op == 6) read = 1'b1;
      tick(1);
    end
    chipselect = 1'b0; read = 1'b0; write_n = 1'b1;
    in_port = '1;
    tick(3);

    reset_n = 1'b0; tick(2);
    reset_n = 1'b1; tick(1);
    check("rst_irq", {31'b0, irq}, 32'h0);
    bus_read(3'd2, d); check("rst_debounce", d, 32'd50000);
    bus_read(3'd1, d); check("rst_mask", d, 32'h0);
    bus_read(3'd3, d); check("rst_edge", d, 32'h0);
    bus_read(3'd4, d); check("rst_event", d, 32'h0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
